// File: rtl/sccb_cfg_seq.sv
// -----------------------------------------------------------------------------
// sccb_cfg_seq
//   Walks a register-table ROM from index 0 and writes each {reg_addr, reg_data}
//   entry to an SCCB (camera control bus) slave with device write ID 8'h42.
//   An entry of 16'hFFFF ends the table. After index 255 the pass ends
//   regardless of content. Each SCCB bit is four clk_200k cycles (q0..q3).
//
// Ports
//   clk_200k  in   system clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse, accepted only in IDLE or DONE
//   rom_addr  out  [7:0]  index into the register-table ROM
//   rom_data  in   [15:0] {reg_addr, reg_data}, registered ROM (1-cycle latency)
//   sio_c     out  SCCB clock
//   sio_d     out  SCCB data value
//   sio_d_oe  out  1 = drive sio_d, 0 = release the pad
//   busy      out  pass in progress
//   done      out  pass finished, held until the next accepted start
//
// Build option
//   SCCB_RESET_DELAY_EN : when defined, a write of reg 8'h12 with data bit 7 set
//   (sensor soft reset) is followed by a 200-cycle (1 ms) wait before the gap.
// -----------------------------------------------------------------------------
module sccb_cfg_seq (
   input  logic        clk_200k,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        sio_c,
   output logic        sio_d,
   output logic        sio_d_oe,
   output logic        busy,
   output logic        done
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_CHECK, S_START, S_SHIFT, S_STOP, S_GAP, S_RWAIT, S_DONE
   } state_t;

   localparam logic [15:0] END_MARK   = 16'hFFFF;
   localparam logic [7:0]  SCCB_WR_ID = 8'h42;
   localparam logic [7:0]  FETCH_LAST = 8'd1;
   localparam logic [7:0]  QTR_LAST   = 8'd3;
   localparam logic [7:0]  GAP_LAST   = 8'd7;
   localparam logic [7:0]  RWAIT_LAST = 8'd199;
   localparam logic [4:0]  BIT_LAST   = 5'd26;

   state_t      state_q,    state_d;
   logic [7:0]  rom_addr_q, rom_addr_d;
   logic [7:0]  cnt_q,      cnt_d;      // quarter / fetch / gap / wait counter
   logic [4:0]  bit_q,      bit_d;      // frame bit index, 0 = first (MSB)
   logic [26:0] frame_q,    frame_d;    // shifts left, bit 26 is on the wire
   logic        dc_bit;
`ifdef SCCB_RESET_DELAY_EN
   logic        rst_wr_q,   rst_wr_d;   // current write is a sensor soft reset
`endif

   // Don't-care (ACK slot) bits: 9th, 18th and 27th of the frame.
   assign dc_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == BIT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk_200k or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rom_addr_q <= 8'd0;
         cnt_q      <= 8'd0;
         bit_q      <= 5'd0;
         frame_q    <= 27'd0;
`ifdef SCCB_RESET_DELAY_EN
         rst_wr_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
`ifdef SCCB_RESET_DELAY_EN
         rst_wr_q   <= rst_wr_d;
`endif
      end
   end

   // NOTE: every signal written here gets a hold default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      frame_d    = frame_q;
`ifdef SCCB_RESET_DELAY_EN
      rst_wr_d   = rst_wr_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               rom_addr_d = 8'd0;
               cnt_d      = 8'd0;
               state_d    = S_FETCH;
            end
         end
         // Two cycles cover the registered ROM latency with rom_addr held.
         S_FETCH: begin
            if (cnt_q == FETCH_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CHECK: begin
            if (rom_data == END_MARK) begin
               state_d = S_DONE;
            end else begin
               frame_d = {SCCB_WR_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
               cnt_d   = 8'd0;
               bit_d   = 5'd0;
               state_d = S_START;
`ifdef SCCB_RESET_DELAY_EN
               rst_wr_d = (rom_data[15:8] == 8'h12) && rom_data[7];
`endif
            end
         end
         S_START: begin
            if (cnt_q == QTR_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == QTR_LAST) begin
               cnt_d   = 8'd0;
               frame_d = {frame_q[25:0], 1'b0};
               if (bit_q == BIT_LAST) begin
                  bit_d   = 5'd0;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == QTR_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_GAP;
`ifdef SCCB_RESET_DELAY_EN
               if (rst_wr_q) state_d = S_RWAIT;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RWAIT: begin
            if (cnt_q == RWAIT_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         // The last table slot ends the pass instead of wrapping rom_addr.
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = 8'd0;
               if (rom_addr_q == 8'hFF) begin
                  state_d = S_DONE;
               end else begin
                  rom_addr_d = rom_addr_q + 8'd1;
                  state_d    = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus outputs are decoded from registered state; idle bus is all ones.
   always_comb begin
      sio_c    = 1'b1;
      sio_d    = 1'b1;
      sio_d_oe = 1'b1;
      case (state_q)
         S_START: sio_d = (cnt_q < 8'd2);
         S_SHIFT: begin
            sio_c    = cnt_q[1];
            sio_d    = dc_bit ? 1'b0 : frame_q[26];
            sio_d_oe = ~dc_bit;
         end
         S_STOP: begin
            sio_c = (cnt_q != 8'd0);
            sio_d = (cnt_q >= 8'd2);
         end
         default: ;
      endcase
   end

   assign rom_addr = rom_addr_q;
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);

endmodule

// File: doc/sccb_cfg_seq.md
SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 clk_200k  input  1  system clock, 200 kHz; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle pulse; begins a configuration pass from ROM index 0.
REQ-004 rom_addr  output  8  ROM index to the register-table ROM.
REQ-005 rom_data  input  16  {reg_addr[15:8], reg_data[7:0]}; ROM is registered, valid 1 cycle after rom_addr; 16'hFFFF = end of table.
REQ-006 sio_c  output  1  SCCB clock.
REQ-007 sio_d  output  1  SCCB data value.
REQ-008 sio_d_oe  output  1  1 = drive sio_d onto pad, 0 = release (high-Z).
REQ-009 busy  output  1  high from accepted start until DONE is entered.
REQ-010 done  output  1  high in DONE, held until next accepted start.

Function
REQ-011 States SHALL be IDLE, FETCH, CHECK, START, SHIFT, STOP, GAP, RWAIT, DONE.
REQ-012 IDLE/DONE: start=1 -> rom_addr<=0, FETCH; otherwise hold; start SHALL be ignored in every other state.
REQ-013 FETCH SHALL last exactly 2 cycles with rom_addr stable, then CHECK.
REQ-014 CHECK (1 cycle): rom_data==16'hFFFF -> DONE; else latch 27-bit frame {8'h42,X,reg_addr,X,reg_data,X} and go START.
REQ-015 Each SCCB bit SHALL occupy 4 cycles (quarters q0-q3): sio_c=0 in q0,q1, sio_c=1 in q2,q3; sio_d changes only at q0.
REQ-016 START (4 cycles): sio_c=1 throughout; sio_d=1 in cycles 0-1, sio_d=0 in cycles 2-3.
REQ-017 SHIFT: 27 bits MSB-first (108 cycles); data bits sio_d_oe=1; don't-care bits (9th, 18th, 27th) sio_d_oe=0, sio_d=0.
REQ-018 STOP (4 cycles): cycle 0 sio_c=0,sio_d=0; cycle 1 sio_c=1,sio_d=0; cycles 2-3 sio_c=1,sio_d=1.
REQ-019 One register write SHALL total 116 cycles START-entry to STOP-exit.
REQ-020 GAP: 8 cycles sio_c=1,sio_d=1,sio_d_oe=1; then rom_addr+1 and FETCH.
REQ-021 After writing index 255 the block SHALL enter DONE without wrapping rom_addr to 0.
REQ-022 Idle bus (IDLE, FETCH, CHECK, GAP, RWAIT, DONE): sio_c=1, sio_d=1, sio_d_oe=1.
REQ-023 busy SHALL rise the cycle after start is sampled; done and busy never high together.

Reset
REQ-024 On rst_n=0: state IDLE, rom_addr=0, sio_c=1, sio_d=1, sio_d_oe=1, busy=0, done=0, bit/quarter/delay counters 0.
REQ-025 Reset mid-transaction SHALL abort immediately to reset values; no STOP is generated.

Configuration
REQ-026 Macro SCCB_RESET_DELAY_EN: when defined, after STOP of a write with reg_addr==8'h12 and reg_data[7]==1, the block SHALL enter RWAIT for 200 cycles (1 ms) before GAP.
REQ-027 When SCCB_RESET_DELAY_EN is undefined, RWAIT SHALL be unreachable and every STOP proceeds directly to GAP.

Verification
REQ-028 ROM {0:16'h1280, 1:16'hFFFF}, start pulse -> one frame: bits 0x42,X,0x12,X,0x80,X; done high; rom_addr=1.
REQ-029 Same table with SCCB_RESET_DELAY_EN -> 200-cycle RWAIT (sio_c=sio_d=1) between STOP and next FETCH; without macro -> GAP only (8 cycles).
REQ-030 ROM 35 entries + 16'hFFFF at 35 -> exactly 35 frames, each 116 cycles with sio_c period 4 cycles; done high with rom_addr=35.
REQ-031 start re-pulsed mid-frame -> ignored, frame bits unchanged; start pulsed in DONE -> restart at rom_addr=0, done drops next cycle.
REQ-032 rst_n low during SHIFT bit 10 -> next cycle sio_c=1, sio_d=1, busy=0, rom_addr=0; no further edges until start.
REQ-033 ROM all 16'h1100 (no terminator) -> 256 frames, then DONE with rom_addr=255.
